// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// controller state encoding and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/Full_Adder.sv
// Single-bit full-adder cell, shared by the bit-serial controller.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell is stepped over WIDTH cycles,
// LSB first, with the result shifted into sum from the MSB end.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  Full_Adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Requests are only honoured outside RUN; a start mid-operation is dropped.
  assign accept   = start && (state_q != ST_RUN);
  assign last_bit = (cnt_q == LAST_BIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      // Subtraction is a + ~b + 1, so the borrow-free case shows as cout = 1.
      opa_d   = a_in;
      opb_d   = sub ? ~b_in : b_in;
      carry_d = sub | cin;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      carry_d = fa_cout;
      cnt_d   = last_bit ? cnt_q : cnt_q + CW'(1);
      if (last_bit) begin
        // carry_q here is the carry into the MSB.
        cout_d = fa_cout;
        ovf_d  = carry_q ^ fa_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH = 8): an arithmetic reference model
// is compared every cycle, plus literal expectations per scenario.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of the operation plus the arithmetic result.
  bit          m_busy, m_done, m_cout, m_ovf;
  int unsigned m_k, m_res, m_fcout, m_fovf, m_sum;
  bit          cmp_en = 1'b0;

  always @(negedge rst_n) begin
    m_busy = 0; m_done = 0; m_cout = 0; m_ovf = 0; m_sum = 0; m_k = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (!m_busy && start) begin
        int unsigned opb, c0, total, low;
        opb   = sub ? (~int'(b_in)) & 32'hFF : int'(b_in);
        c0    = sub ? 1 : int'(cin);
        total = int'(a_in) + opb + c0;
        low   = (int'(a_in) & 32'h7F) + (opb & 32'h7F) + c0;
        m_res   = total & 32'hFF;
        m_fcout = (total >> 8) & 1;
        m_fovf  = ((low >> 7) & 1) ^ m_fcout;
        m_busy = 1; m_done = 0; m_k = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
      end else if (m_busy) begin
        m_k++;
        if (m_k == W) begin
          m_busy = 0; m_done = 1;
          m_sum  = m_res;
          m_cout = m_fcout[0];
          m_ovf  = m_fovf[0];
        end else begin
          m_sum = (m_res << (W - m_k)) & 32'hFF;
        end
      end else begin
        m_done = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_sum",  32'(sum),  m_sum);
      chk("model_cout", 32'(cout), 32'(m_cout));
      chk("model_ovf",  32'(ovf),  32'(m_ovf));
    end
  end

  // Drive a request at a negedge; it is sampled at the next rising edge (E0).
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
    sub = s; a_in = a; b_in = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count rising edges after the caller's position until done is seen.
  task automatic wait_done(input string name, input int exp_cycles,
                           input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    chk({name, "_latency"}, 32'(n), 32'(exp_cycles));
    chk({name, "_sum"},  32'(sum),  32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"},  32'(ovf),  32'(eo));
    $display("op %s: sum=0x%02h cout=%0b ovf=%0b cycles=%0d", name, sum, cout, ovf, n);
  endtask

  initial begin
    logic [W-1:0] held;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    start_op(1'b0, 8'h5A, 8'h3C, 1'b0);
    wait_done("add_5a_3c", 8, 8'h96, 1'b0, 1'b1);
    @(negedge clk);

    start_op(1'b0, 8'hFF, 8'h01, 1'b0);
    wait_done("add_ff_01", 8, 8'h00, 1'b1, 1'b0);
    @(negedge clk);

    start_op(1'b0, 8'h00, 8'h00, 1'b1);
    wait_done("add_cin", 8, 8'h01, 1'b0, 1'b0);
    @(negedge clk);

    start_op(1'b1, 8'h10, 8'h20, 1'b0);
    wait_done("sub_10_20", 8, 8'hF0, 1'b0, 1'b0);

    // Back-to-back: request while DONE is showing.
    start_op(1'b1, 8'h80, 8'h01, 1'b1);
    #3;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    wait_done("sub_80_01", 8, 8'h7F, 1'b1, 1'b1);
    @(negedge clk);

    // Start pulsed mid-RUN with different operands must be ignored.
    start_op(1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    sub = 1'b1; a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_mid", 5, 8'h46, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset after bit 3 has been processed.
    start_op(1'b0, 8'hF0, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(1'b0, 8'h01, 8'h01, 1'b0);
    wait_done("after_rst", 8, 8'h02, 1'b0, 1'b0);
    held = sum;

    // Hold: operands wiggle with start low; result and idle state persist.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a_in = W'($urandom);
      b_in = W'($urandom);
      cin  = 1'($urandom);
      sub  = 1'($urandom);
    end
    @(negedge clk);
    chk("hold_sum",  32'(sum),  32'(held));
    chk("hold_cout", 32'(cout), 32'd0);
    chk("hold_ovf",  32'(ovf),  32'd0);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_done", 32'(done), 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller. It sequences one 1-bit full-adder cell over WIDTH clock cycles to produce a WIDTH-bit sum or difference, LSB first. It sits between a requester issuing operands with a start pulse and the single shared full-adder cell, and trades area for latency in the lab ALU datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+cin, 1 = a-b (b inverted, carry-in forced 1, cin ignored); captured with start.
- a_in  input  WIDTH  operand A; captured with start.
- b_in  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; high only in DONE.
- sum  output  WIDTH  result; valid from DONE and held until the next accepted start.
- cout  output  1  carry out of MSB. For subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- State machine: IDLE → RUN on start; RUN → DONE when the bit counter reaches WIDTH-1; DONE → RUN on start, otherwise DONE → IDLE.
- On an accepted start:
  - opa ← a_in; opb ← sub ? ~b_in : b_in.
  - Carry flop ← sub ? 1 : cin.
  - Counter ← 0; sum register cleared to 0; cout and ovf cleared.
- Each RUN cycle:
  - The full-adder cell inputs are opa[0], opb[0] and the carry flop.
  - Its sum output shifts into sum at the MSB, with sum shifting right by 1.
  - opa and opb shift right by 1; the carry flop ← cell cout; counter increments.
- On the final RUN cycle (counter = WIDTH-1):
  - cout ← cell cout.
  - ovf ← carry flop (carry into MSB) XOR cell cout.
- Start during RUN is ignored. No queueing, no error flag.
- Operand inputs are don't-care except in the cycle start is accepted.
- Reset (asynchronous, any time, including mid-RUN):
  - State = IDLE; counter, carry, opa, opb, sum, cout, ovf, busy and done all go to 0.
  - Any in-flight operation is discarded.
- All arithmetic is modulo 2^WIDTH; the counter is $clog2(WIDTH) bits wide and never wraps inside RUN.

## Timing
- Edge E0 samples start = 1; busy = 1 after E0.
- Edges E1..E(WIDTH) process bits 0..WIDTH-1.
- After E(WIDTH): busy = 0, done = 1; sum, cout and ovf are valid.
- After E(WIDTH+1): done = 0 unless a new start was sampled at that edge. If it was, busy = 1 immediately, so back-to-back operations have no idle gap.
- Latency from start edge to done is WIDTH cycles. Throughput is one operation per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - State encoding constants: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
  - Default WIDTH = 8.
- One sub-module: the team's existing Full_Adder cell (ports a, b, c, s, cout), instantiated exactly once.
- The FSM, counter, shift registers and carry flop live in serial_add_ctrl.

## Test plan
All scenarios use WIDTH = 8.
- Add 0x5A + 0x3C, cin = 0 → done exactly 8 cycles after the start edge; sum = 0x96, cout = 0, ovf = 1.
- Add 0xFF + 0x01, cin = 0 → sum = 0x00, cout = 1, ovf = 0. Then 0x00 + 0x00 with cin = 1 → sum = 0x01, cout = 0.
- Sub 0x10 − 0x20 → sum = 0xF0, cout = 0, ovf = 0. Sub 0x80 − 0x01 → sum = 0x7F, cout = 1, ovf = 1.
- Back-to-back and overlap:
  - Pulse start during DONE → next operation's busy = 1 the following cycle and done arrives 8 cycles later.
  - Pulse start mid-RUN with different operands → ignored; the first result is unchanged.
- Reset mid-operation: deassert rst_n asynchronously after bit 3 → busy, done, sum, cout and ovf go to 0 immediately. After release, a new add 0x01 + 0x01 gives sum = 0x02.
- Hold check: after done, change a_in/b_in freely for 20 cycles with start = 0 → sum, cout and ovf unchanged; state remains IDLE.
